// File: rtl/diad_pkg.sv
// rtl/diad_pkg.sv - shared types and widths for the diad pipeline stages
package diad_pkg;

    localparam int PC_W = 12;
    localparam int DW   = 24;
    localparam int RW   = 4;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ma_state_t;

endpackage

// File: rtl/stage4ma_if.sv
// rtl/stage4ma_if.sv - data-memory req/ack bus between the memory-access stage and data memory
interface stage4ma_if;
    import diad_pkg::*;

    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/stage4ma.sv
// rtl/stage4ma.sv - diad memory-access stage: pass-through for ALU ops, req/ack access for loads and stores
module stage4ma
    import diad_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            flush,
    input  logic [PC_W-1:0] pc_in,
    input  logic [1:0]      mem_op_in,
    input  logic [DW-1:0]   result_in,
    input  logic [DW-1:0]   store_data_in,
    input  logic [RW-1:0]   rd_in,
    input  logic            rd_we_in,
    output logic            stall_out,
    stage4ma_if.master      mem,
    output logic [PC_W-1:0] pc_out,
    output logic            enable_out,
    output logic [DW-1:0]   wb_data_out,
    output logic [RW-1:0]   rd_out,
    output logic            rd_we_out
);

    ma_state_t       r_state;
    ma_state_t       w_next_state;

    logic            r_mem_req;
    logic            r_mem_we;
    logic [DW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [PC_W-1:0] r_pc_lat;
    logic [RW-1:0]   r_rd_lat;
    logic [PC_W-1:0] r_pc_out;
    logic            r_enable_out;
    logic [DW-1:0]   r_wb_data;
    logic [RW-1:0]   r_rd_out;
    logic            r_rd_we_out;

    logic            w_capture;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_mem;

    // 2'b11 decodes as neither load nor store, so it falls through as a plain op
    assign w_capture  = enable && !flush;
    assign w_is_load  = (mem_op_in == MEM_LOAD);
    assign w_is_store = (mem_op_in == MEM_STORE);
    assign w_is_mem   = w_is_load || w_is_store;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: enter WAIT on a captured memory op, leave only on ack
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_capture && w_is_mem) w_next_state = WAIT;
            WAIT:    if (mem.mem_ack)           w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Memory request, latched instruction context and write-back registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_pc_lat     <= '0;
            r_rd_lat     <= '0;
            r_pc_out     <= '0;
            r_enable_out <= 1'b0;
            r_wb_data    <= '0;
            r_rd_out     <= '0;
            r_rd_we_out  <= 1'b0;
        end else begin
            r_enable_out <= 1'b0;
            r_rd_we_out  <= 1'b0;
            if (r_state == IDLE) begin
                if (w_capture) begin
                    if (w_is_mem) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_is_store;
                        r_mem_addr  <= result_in;
                        r_mem_wdata <= w_is_store ? store_data_in : '0;
                        r_pc_lat    <= pc_in;
                        r_rd_lat    <= rd_in;
                    end else begin
                        r_enable_out <= 1'b1;
                        r_pc_out     <= pc_in;
                        r_wb_data    <= result_in;
                        r_rd_out     <= rd_in;
                        r_rd_we_out  <= rd_we_in;
                    end
                end
            end else if (mem.mem_ack) begin
                // r_mem_we doubles as the latched "this is a store" flag
                r_mem_req    <= 1'b0;
                r_enable_out <= 1'b1;
                r_pc_out     <= r_pc_lat;
                r_rd_out     <= r_rd_lat;
                r_wb_data    <= r_mem_we ? r_mem_addr : mem.mem_rdata;
                r_rd_we_out  <= !r_mem_we;
            end
        end
    end

    assign stall_out     = (r_state == WAIT);
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign pc_out        = r_pc_out;
    assign enable_out    = r_enable_out;
    assign wb_data_out   = r_wb_data;
    assign rd_out        = r_rd_out;
    assign rd_we_out     = r_rd_we_out;

endmodule

// File: doc/stage4ma.md
Name: stage4ma

Overview:
- Memory-access stage of the diad pipeline. It sits directly downstream of the execute stage and upstream of write-back.
- Non-memory instructions pass through with one registered cycle of latency.
- Loads and stores run a req/ack handshake to data memory. The stage stalls upstream until the access completes.
- Carries the 12-bit PC alongside the result so later stages see the instruction's PC.

Parameters:
- PC_W, 12, program counter width
- DW, 24, data and memory-address width
- RW, 4, register index width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- enable  in  1  valid instruction from execute stage
- flush  in  1  kill the instruction being captured this cycle
- pc_in  in  PC_W  PC of incoming instruction
- mem_op_in  in  2  MEM_NONE/MEM_LOAD/MEM_STORE
- result_in  in  DW  ALU result; used as memory address for load/store
- store_data_in  in  DW  store data
- rd_in  in  RW  destination register
- rd_we_in  in  1  destination write enable (non-memory ops)
- stall_out  out  1  upstream must hold its outputs
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  DW  memory address
- mem_wdata  out  DW  store data
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  DW  load data, valid when mem_ack=1
- pc_out  out  PC_W  PC to write-back
- enable_out  out  1  valid to write-back
- wb_data_out  out  DW  write-back value
- rd_out  out  RW  destination register
- rd_we_out  out  1  register write enable

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, pc_out, enable_out, wb_data_out, rd_out, rd_we_out, stall_out.
  - Reset during WAIT drops mem_req immediately. The transaction is abandoned and a later mem_ack is ignored.
- FSM states: IDLE, WAIT. stall_out = (state==WAIT), combinational from state.
- IDLE, capture condition = enable & !flush:
  - MEM_NONE: next cycle enable_out=1, pc_out=pc_in, wb_data_out=result_in, rd_out=rd_in, rd_we_out=rd_we_in. Stay in IDLE.
  - MEM_LOAD or MEM_STORE: latch pc, rd, op. Next cycle mem_req=1, mem_we=(op==STORE), mem_addr=result_in, mem_wdata=store_data_in (0 for load). Move to WAIT. enable_out=0.
  - Op encoding 2'b11 is treated as MEM_NONE.
  - No capture (enable=0 or flush=1): next cycle enable_out=0, rd_we_out=0. Other outputs hold their last values.
- WAIT:
  - mem_req and all mem_* outputs stay stable until ack.
  - enable, flush and all data inputs are ignored. Upstream holds its outputs because stall_out=1.
  - On mem_ack=1, next cycle:
    - mem_req=0, state=IDLE, enable_out=1, pc_out=latched pc, rd_out=latched rd.
    - Load: wb_data_out=mem_rdata, rd_we_out=1.
    - Store: wb_data_out=mem_addr, rd_we_out=0.
  - stall_out falls the same cycle the result is presented. Upstream may present a new instruction that cycle, and it is captured in IDLE.
  - Flush during WAIT has no effect: an issued access always completes.
- mem_ack while IDLE is ignored.
- Minimum load/store occupancy: 2 cycles (ack in the first WAIT cycle). Back-to-back loads therefore produce one result every 2 cycles.
- enable_out is high for exactly one cycle per retired instruction.

Decomposition:
- Shared package diad_pkg:
  - mem_op_t: MEM_NONE=2'b00, MEM_LOAD=2'b01, MEM_STORE=2'b10.
  - ma_state_t: IDLE, WAIT.
  - Width localparams PC_W, DW, RW, shared with the other stages.
- No sub-module: the FSM and the output registers form a single module.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: start a load, assert rst while mem_req=1, release rst, then pulse mem_ack.
  - Required: mem_req drops asynchronously; all outputs read 0; the stray ack produces enable_out=0.
- Pass-through:
  - Stimulus: enable=1, op=NONE, pc_in=12'h010, result_in=24'h00ABCD, rd_in=3, rd_we_in=1.
  - Required: next cycle enable_out=1, pc_out=12'h010, wb_data_out=24'h00ABCD, rd_out=3, rd_we_out=1; stall_out stays 0.
- Load with 3 wait cycles:
  - Stimulus: op=LOAD, result_in=24'h000100, pc_in=12'h024, rd=5; memory acks in the 3rd WAIT cycle with mem_rdata=24'h123456.
  - Required: mem_req=1 and mem_addr=24'h000100 for 3 cycles; stall_out=1 for 3 cycles; then enable_out=1, pc_out=12'h024, wb_data_out=24'h123456, rd_out=5, rd_we_out=1.
- Store, zero-wait ack, then back-to-back NONE:
  - Stimulus: op=STORE, addr=24'h000200, data=24'hCAFE00; mem_ack in the first WAIT cycle; a NONE instruction presented as soon as stall_out falls.
  - Required: mem_we=1, mem_wdata=24'hCAFE00; the store retires with rd_we_out=0; the NONE retires the following cycle.
- Flush:
  - Stimulus: flush=1 with a LOAD presented in IDLE.
  - Required: no mem_req and enable_out=0.
  - Stimulus: flush=1 during WAIT.
  - Required: the transaction still completes and retires on ack.
